decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, datapath and register width; legal values are 16 or more.
REQ-002 The block SHALL have parameter NREG, default 8, number of architectural registers; legal values are powers of two, 8 or more.
REQ-003 The block SHALL have parameter SEL_W, default $clog2(NREG), register-select width; fields wider than 3 bits are zero-extended from instruction fields.
REQ-004 The block SHALL have a single clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have the following instruction and control inputs:
- in_instr  in  16  instruction word.
- in_valid  in  1  in_instr is valid this cycle.
- in_reg_dest  in  2  destination select: 0=instr[7:5], 1=instr[10:8], 2=instr[4:2], 3=NREG-1.
- in_reg_write  in  1  instruction writes a register.
- in_mem_read  in  1  instruction is a load.
- in_zero_ext  in  1  zero-extend imm5/imm8 (else sign-extend).
- in_halt  in  1  instruction is a halt.
- flush  in  1  squash the instruction in decode and the ID/EX register.
REQ-006 The block SHALL have the following writeback inputs:
- wb_en  in  1  writeback enable.
- wb_sel  in  SEL_W  writeback register.
- wb_data  in  DATA_W  writeback data.
REQ-007 The block SHALL have the following registered ID/EX outputs:
- out_valid  out  1  ID/EX slot holds a real instruction.
- out_rs_data  out  DATA_W  register read at instr[10:8].
- out_rt_data  out  DATA_W  register read at instr[7:5].
- out_rs_sel  out  SEL_W  source select instr[10:8].
- out_rt_sel  out  SEL_W  source select instr[7:5].
- out_imm5  out  DATA_W  extended instr[4:0].
- out_imm8  out  DATA_W  extended instr[7:0].
- out_imm11  out  DATA_W  sign-extended instr[10:0].
- out_wr_reg  out  SEL_W  resolved destination register.
- out_reg_write  out  1  qualified register write.
- out_mem_read  out  1  qualified load.
- out_halt  out  1  qualified halt.
REQ-008 The block SHALL have the following status outputs:
- stall  out  1  combinational; upstream holds in_instr this cycle.
- halted  out  1  registered; halt has issued.

Function
REQ-009 The register file SHALL hold NREG entries of DATA_W bits and SHALL write wb_data to wb_sel on a rising edge when wb_en=1.
REQ-010 Reads SHALL be write-bypassed: when wb_en=1 and wb_sel equals the read select, the read SHALL return wb_data in the same cycle.
REQ-011 Load-use hazard SHALL be detected and stall asserted when out_valid & out_mem_read & out_reg_write are all 1, in_valid=1, and out_wr_reg equals rs_sel or rt_sel.
REQ-012 On stall, the ID/EX register SHALL load a bubble (out_valid=0, all qualified bits 0), and the block SHALL re-evaluate the same in_instr next cycle; a stall SHALL last exactly 1 cycle per hazard.
REQ-013 When flush=1, the next edge SHALL load a bubble, stall SHALL be 0, and flush SHALL take priority over stall.
REQ-014 On no stall, no flush, and in_valid=1, the ID/EX register SHALL capture all decoded fields with out_valid=1.
REQ-015 When in_valid=0, the ID/EX register SHALL capture a bubble.
REQ-016 out_reg_write, out_mem_read, and out_halt SHALL be ANDed with the capture condition; the data fields of a bubble are don't-care.
REQ-017 Latency from in_instr to the out_* fields SHALL be 1 cycle, excluding stall cycles.
REQ-018 An issued instruction with out_halt=1 SHALL set halted on the same edge; halted SHALL be sticky until rst.
REQ-019 While halted=1, all captures SHALL be bubbles and stall SHALL be 0.
REQ-020 Immediates SHALL be extended to DATA_W: imm5/imm8 zero- or sign-extended per in_zero_ext, imm11 always sign-extended.
REQ-021 A destination select of 3 SHALL resolve to NREG-1 for any NREG.

Reset
REQ-022 On rst, every register-file entry SHALL be 0, and out_valid, out_reg_write, out_mem_read, out_halt, and halted SHALL be 0.
REQ-023 On rst, all other out_* fields SHALL be 0.
REQ-024 rst SHALL override flush, stall, and wb_en in the same cycle; a writeback coincident with rst SHALL be discarded.

Verification
REQ-025 The bench SHALL cover the bypass case: wb_en=1, wb_sel=3, wb_data=0x1234 while in_instr reads r3 as rs -> out_rs_data=0x1234 the next cycle.
REQ-026 The bench SHALL cover load-use: a load writing r2 issues, then the next instruction reads r2 as rt -> stall=1 for 1 cycle, out_valid=0 for one cycle, then the instruction issues with out_valid=1.
REQ-027 The bench SHALL cover flush with stall: flush=1 while a hazard is present -> stall=0 and out_valid=0 the next cycle.
REQ-028 The bench SHALL cover immediates with DATA_W=32: instr[7:0]=0x80 with in_zero_ext=0 -> out_imm8=0xFFFFFF80; with in_zero_ext=1 -> 0x00000080.
REQ-029 The bench SHALL cover halt: a halt issues -> halted=1, and subsequent valid instructions produce out_valid=0 until rst.
REQ-030 The bench SHALL cover NREG=16 with in_reg_dest=3 -> out_wr_reg=15.

Source files
------------

// File: rtl/decode_pipe.sv
// Decode stage with register file and ID/EX register; 1-cycle latency in_instr -> out_*.
// Backpressure: one-cycle stall on load-use (bubble inserted); flush beats stall; halt is sticky.
module decode_pipe #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int SEL_W  = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       in_instr,
   input  logic              in_valid,
   input  logic [1:0]        in_reg_dest,
   input  logic              in_reg_write,
   input  logic              in_mem_read,
   input  logic              in_zero_ext,
   input  logic              in_halt,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [SEL_W-1:0]  wb_sel,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_rs_data,
   output logic [DATA_W-1:0] out_rt_data,
   output logic [SEL_W-1:0]  out_rs_sel,
   output logic [SEL_W-1:0]  out_rt_sel,
   output logic [DATA_W-1:0] out_imm5,
   output logic [DATA_W-1:0] out_imm8,
   output logic [DATA_W-1:0] out_imm11,
   output logic [SEL_W-1:0]  out_wr_reg,
   output logic              out_reg_write,
   output logic              out_mem_read,
   output logic              out_halt,
   output logic              stall,
   output logic              halted
);

   logic [DATA_W-1:0] rf [NREG];
   logic [SEL_W-1:0]  rs_sel, rt_sel, wr_reg;
   logic [DATA_W-1:0] rs_data, rt_data, imm5, imm8, imm11;
   logic              hazard, capture;
   logic              unused_hi;

   assign unused_hi = ^in_instr[15:11];

   assign rs_sel = SEL_W'(in_instr[10:8]);
   assign rt_sel = SEL_W'(in_instr[7:5]);

   // Same-cycle writeback is forwarded so a reader never sees stale data.
   assign rs_data = (wb_en && (wb_sel == rs_sel)) ? wb_data : rf[rs_sel];
   assign rt_data = (wb_en && (wb_sel == rt_sel)) ? wb_data : rf[rt_sel];

   assign imm5  = in_zero_ext ? {{(DATA_W-5){1'b0}}, in_instr[4:0]}
                              : {{(DATA_W-5){in_instr[4]}}, in_instr[4:0]};
   assign imm8  = in_zero_ext ? {{(DATA_W-8){1'b0}}, in_instr[7:0]}
                              : {{(DATA_W-8){in_instr[7]}}, in_instr[7:0]};
   assign imm11 = {{(DATA_W-11){in_instr[10]}}, in_instr[10:0]};

   always_comb begin
      wr_reg = rt_sel;
      case (in_reg_dest)
         2'd0:    wr_reg = rt_sel;
         2'd1:    wr_reg = rs_sel;
         2'd2:    wr_reg = SEL_W'(in_instr[4:2]);
         default: wr_reg = SEL_W'(NREG - 1);
      endcase
   end

   assign hazard  = out_valid & out_mem_read & out_reg_write & in_valid &
                    ((out_wr_reg == rs_sel) | (out_wr_reg == rt_sel));
   assign stall   = hazard & ~flush & ~halted;
   assign capture = in_valid & ~stall & ~flush & ~halted;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wb_en) begin
         rf[wb_sel] <= wb_data;
      end
   end

   // Data fields load every cycle; only the qualifiers mark a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid     <= 1'b0;
         out_rs_data   <= '0;
         out_rt_data   <= '0;
         out_rs_sel    <= '0;
         out_rt_sel    <= '0;
         out_imm5      <= '0;
         out_imm8      <= '0;
         out_imm11     <= '0;
         out_wr_reg    <= '0;
         out_reg_write <= 1'b0;
         out_mem_read  <= 1'b0;
         out_halt      <= 1'b0;
         halted        <= 1'b0;
      end else begin
         out_valid     <= capture;
         out_rs_data   <= rs_data;
         out_rt_data   <= rt_data;
         out_rs_sel    <= rs_sel;
         out_rt_sel    <= rt_sel;
         out_imm5      <= imm5;
         out_imm8      <= imm8;
         out_imm11     <= imm11;
         out_wr_reg    <= wr_reg;
         out_reg_write <= capture & in_reg_write;
         out_mem_read  <= capture & in_mem_read;
         out_halt      <= capture & in_halt;
         halted        <= halted | (capture & in_halt);
      end
   end

endmodule

// File: tb/tb_decode_pipe.sv
// Scoreboard bench for decode_pipe at DATA_W=32, NREG=16.
module tb_decode_pipe;
   localparam int DW = 32;
   localparam int NR = 16;
   localparam int SW = 4;

   logic          clk, rst;
   logic [15:0]   in_instr;
   logic          in_valid, in_reg_write, in_mem_read, in_zero_ext, in_halt, flush;
   logic [1:0]    in_reg_dest;
   logic          wb_en;
   logic [SW-1:0] wb_sel;
   logic [DW-1:0] wb_data;
   logic          out_valid, out_reg_write, out_mem_read, out_halt, stall, halted;
   logic [DW-1:0] out_rs_data, out_rt_data, out_imm5, out_imm8, out_imm11;
   logic [SW-1:0] out_rs_sel, out_rt_sel, out_wr_reg;

   decode_pipe #(.DATA_W(DW), .NREG(NR), .SEL_W(SW)) dut (
      .clk(clk), .rst(rst), .in_instr(in_instr), .in_valid(in_valid),
      .in_reg_dest(in_reg_dest), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
      .in_zero_ext(in_zero_ext), .in_halt(in_halt), .flush(flush),
      .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
      .out_valid(out_valid), .out_rs_data(out_rs_data), .out_rt_data(out_rt_data),
      .out_rs_sel(out_rs_sel), .out_rt_sel(out_rt_sel), .out_imm5(out_imm5),
      .out_imm8(out_imm8), .out_imm11(out_imm11), .out_wr_reg(out_wr_reg),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_halt(out_halt),
      .stall(stall), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] rs_data;
      logic [DW-1:0] rt_data;
      logic [SW-1:0] rs_sel;
      logic [SW-1:0] rt_sel;
      logic [DW-1:0] imm5;
      logic [DW-1:0] imm8;
      logic [DW-1:0] imm11;
      logic [SW-1:0] wr_reg;
      logic          rw;
      logic          mr;
      logic          hlt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic exp_t mk(input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                               input logic [SW-1:0] rss, input logic [SW-1:0] rts,
                               input logic [DW-1:0] i5, input logic [DW-1:0] i8,
                               input logic [DW-1:0] i11, input logic [SW-1:0] wr,
                               input logic rw, input logic mr, input logic hlt);
      exp_t e;
      e = {rsd, rtd, rss, rts, i5, i8, i11, wr, rw, mr, hlt};
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, want);
      end
   endtask

   // Monitor: every issued instruction must match the oldest expectation.
   always @(negedge clk) begin
      exp_t act, want;
      if (!rst && out_valid) begin
         act = {out_rs_data, out_rt_data, out_rs_sel, out_rt_sel, out_imm5, out_imm8,
                out_imm11, out_wr_reg, out_reg_write, out_mem_read, out_halt};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_issue actual=out_valid=1 fields=%h required=bubble", act);
         end else begin
            want = exp_q.pop_front();
            if (act !== want) begin
               errors++;
               $display("FAIL issue_fields actual=%h required=%h", act, want);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 0; in_instr = '0; in_reg_dest = 0; in_reg_write = 0;
      in_mem_read = 0; in_zero_ext = 0; in_halt = 0;
   endtask

   task automatic drive(input logic [15:0] instr, input logic [1:0] dest,
                        input logic rw, input logic mr, input logic zx, input logic hlt);
      in_valid = 1; in_instr = instr; in_reg_dest = dest; in_reg_write = rw;
      in_mem_read = mr; in_zero_ext = zx; in_halt = hlt;
   endtask

   task automatic wb(input logic [SW-1:0] sel, input logic [DW-1:0] data);
      wb_en = 1; wb_sel = sel; wb_data = data;
   endtask

   initial begin
      idle();
      flush = 0;
      rst = 1;
      wb(5, 32'hDEAD);
      tick(); tick();
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_halted", {31'd0, halted}, 0);
      chk("rst_stall", {31'd0, stall}, 0);
      chk("rst_rs_data", out_rs_data, 0);
      chk("rst_imm11", out_imm11, 0);
      chk("rst_qual", {29'd0, out_reg_write, out_mem_read, out_halt}, 0);
      tick();
      rst = 0; wb_en = 0;

      wb(1, 32'h11111111); tick();
      wb(2, 32'h22222222); tick();
      wb(4, 32'h44444444); tick();

      // bypass: r3 written this cycle and read as rs
      wb(3, 32'h1234);
      drive(16'h0325, 0, 1, 0, 0, 0);
      exp_q.push_back(mk(32'h1234, 32'h11111111, 3, 1, 32'h5, 32'h25, 32'h325, 1, 1, 0, 0));
      tick();
      wb_en = 0;

      drive(16'h0080, 2, 0, 0, 0, 0);
      exp_q.push_back(mk(0, 32'h44444444, 0, 4, 0, 32'hFFFFFF80, 32'h80, 0, 0, 0, 0));
      tick();
      drive(16'h0080, 2, 0, 0, 1, 0);
      exp_q.push_back(mk(0, 32'h44444444, 0, 4, 0, 32'h00000080, 32'h80, 0, 0, 0, 0));
      tick();
      drive(16'h0015, 2, 0, 0, 0, 0);
      exp_q.push_back(mk(0, 0, 0, 0, 32'hFFFFFFF5, 32'h15, 32'h15, 5, 0, 0, 0));
      tick();
      drive(16'h0015, 2, 0, 0, 1, 0);
      exp_q.push_back(mk(0, 0, 0, 0, 32'h15, 32'h15, 32'h15, 5, 0, 0, 0));
      tick();
      drive(16'hF400, 1, 0, 0, 1, 0);
      exp_q.push_back(mk(32'h44444444, 0, 4, 0, 0, 0, 32'hFFFFFC00, 4, 0, 0, 0));
      tick();
      drive(16'h0000, 3, 1, 0, 0, 0);
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 15, 1, 0, 0));
      tick();
      idle(); tick();

      // load-use: load r2, consumer reads r2 as rt
      drive(16'h0144, 0, 1, 1, 0, 0);
      exp_q.push_back(mk(32'h11111111, 32'h22222222, 1, 2, 32'h4, 32'h44, 32'h144, 2, 1, 1, 0));
      tick();
      drive(16'h0440, 1, 1, 0, 0, 0);
      exp_q.push_back(mk(32'h44444444, 32'h22222222, 4, 2, 0, 32'h40, 32'hFFFFFC40, 4, 1, 0, 0));
      @(negedge clk);
      chk("loaduse_stall", {31'd0, stall}, 1);
      tick();
      @(negedge clk);
      chk("loaduse_stall_len", {31'd0, stall}, 0);
      chk("loaduse_bubble", {31'd0, out_valid}, 0);
      tick();
      @(negedge clk);
      chk("loaduse_after", {31'd0, stall}, 0);
      idle(); tick();

      // flush while the same hazard is present
      drive(16'h0144, 0, 1, 1, 0, 0);
      exp_q.push_back(mk(32'h11111111, 32'h22222222, 1, 2, 32'h4, 32'h44, 32'h144, 2, 1, 1, 0));
      tick();
      drive(16'h0440, 1, 1, 0, 0, 0);
      flush = 1;
      @(negedge clk);
      chk("flush_stall", {31'd0, stall}, 0);
      tick();
      flush = 0; idle();
      @(negedge clk);
      chk("flush_bubble", {31'd0, out_valid}, 0);
      tick();

      // halt, then valid instructions must be dropped
      drive(16'h0000, 0, 0, 0, 0, 1);
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      tick();
      @(negedge clk);
      chk("halt_set", {31'd0, halted}, 1);
      for (int i = 0; i < 3; i++) begin
         drive(16'h0325, 0, 1, 1, 0, 0);
         tick();
         @(negedge clk);
         chk("halt_bubble", {31'd0, out_valid}, 0);
         chk("halt_sticky", {31'd0, halted}, 1);
         chk("halt_stall", {31'd0, stall}, 0);
      end

      // reset clears halt and register file; coincident writeback dropped
      rst = 1;
      wb(5, 32'hDEAD);
      tick();
      @(negedge clk);
      chk("rst2_halted", {31'd0, halted}, 0);
      chk("rst2_out_valid", {31'd0, out_valid}, 0);
      tick();
      rst = 0; wb_en = 0;
      drive(16'h0560, 0, 1, 0, 0, 0);
      exp_q.push_back(mk(0, 0, 5, 3, 0, 32'h60, 32'hFFFFFD60, 3, 1, 0, 0));
      tick();
      idle(); tick(); tick();

      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
